spi_wb_sequencer: RTL and testbench

//  Hardware Wishbone master that runs complete SPI transfers on spi_top with no CPU involvement.

---
 rtl/spi_wb_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_wb_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_sequencer.sv
// spi_wb_sequencer: Wishbone master that runs complete SPI transfers on spi_top.
// One request programs CTRL, DIVIDER, SS, TX0 and CTRL|GO. The block then polls
// GO_BSY, reads RX0 and returns the word (or an error) on a valid/ready port.
module spi_wb_sequencer #(
  parameter int SS_NB       = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_POLLS   = 256,
  parameter int POLL_GAP    = 4
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_tx_data,
  input  logic [6:0]       req_char_len,
  input  logic [4:0]       req_mode,
  input  logic [15:0]      req_divider,
  input  logic [SS_NB-1:0] req_ss,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rx_data,
  output logic             rsp_err,
  output logic [4:0]       wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam logic [4:0] ADR_TX0  = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;

  localparam int TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'((MAX_POLLS > 0) ? MAX_POLLS - 1 : 0);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_W_CTRL = 4'd1,
    S_W_DIV  = 4'd2,
    S_W_SS   = 4'd3,
    S_W_TX   = 4'd4,
    S_W_GO   = 4'd5,
    S_GAP    = 4'd6,
    S_POLL   = 4'd7,
    S_RD_RX  = 4'd8,
    S_RESP   = 4'd9
  } state_e;

  // With no gap configured the next poll follows the access idle cycle directly.
  localparam state_e S_TO_POLL = (POLL_GAP > 0) ? S_GAP : S_POLL;

  // CTRL layout: ASS/IE/LSB in [13:11], TX_NEG [10], RX_NEG [9], GO [8], CHAR_LEN [6:0].
  function automatic logic [31:0] ctrl_word(input logic [4:0] mode, input logic [6:0] len);
    return {18'h0, mode[4:2], mode[1], mode[0], 1'b0, 1'b0, len};
  endfunction

  function automatic logic [31:0] ss_word(input logic [SS_NB-1:0] ss);
    logic [31:0] w;
    w = 32'h0;
    w[SS_NB-1:0] = ss;
    return w;
  endfunction

  function automatic logic is_bus(input state_e s);
    case (s)
      S_W_CTRL, S_W_DIV, S_W_SS, S_W_TX, S_W_GO, S_POLL, S_RD_RX: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Successor once an access has finished its trailing idle cycle.
  function automatic state_e after_access(input state_e s, input logic busy);
    case (s)
      S_W_CTRL: return S_W_DIV;
      S_W_DIV:  return S_W_SS;
      S_W_SS:   return S_W_TX;
      S_W_TX:   return S_W_GO;
      S_W_GO:   return S_TO_POLL;
      S_POLL:   return busy ? S_TO_POLL : S_RD_RX;
      S_RD_RX:  return S_RESP;
      default:  return S_IDLE;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic               done_q, done_d;     // access acked, now in its idle cycle
  logic [TMO_W-1:0]   tmo_q;
  logic [POLL_W-1:0]  poll_q;
  logic [GAP_W-1:0]   gap_q;
  logic               busy_q;
  logic [31:0]        tx_q, rx_q;
  logic [6:0]         len_q;
  logic [4:0]         mode_q;
  logic [15:0]        div_q;
  logic [SS_NB-1:0]   ss_q;
  logic               err_q;

  logic               capture_s, active_s, ack_s, err_s, tmo_s, poll_abort_s, abort_s;
  logic [31:0]        ctrl_s;

  logic               cyc_d, cyc_q, we_d, we_q, rsp_valid_d, rsp_valid_q, req_ready_d, req_ready_q;
  logic [4:0]         adr_d, adr_q;
  logic [31:0]        dat_d, dat_q;
  logic [3:0]         sel_d, sel_q;

  // Bus event decode; a same-cycle error wins over ack.
  always_comb begin
    capture_s    = (state_q == S_IDLE) && req_valid;
    active_s     = is_bus(state_q) && !done_q;
    err_s        = active_s && wb_err_i;
    ack_s        = active_s && wb_ack_i && !wb_err_i;
    tmo_s        = active_s && !wb_ack_i && !wb_err_i && (tmo_q == TMO_LAST);
    poll_abort_s = ack_s && (state_q == S_POLL) && wb_dat_i[8] && (poll_q == POLL_LAST);
    abort_s      = err_s || tmo_s || poll_abort_s;
    ctrl_s       = capture_s ? ctrl_word(req_mode, req_char_len) : ctrl_word(mode_q, len_q);
  end

  // State register.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (capture_s) state_d = S_W_CTRL;
        else           state_d = S_IDLE;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_POLL;
        else                   state_d = S_GAP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
        else           state_d = S_RESP;
      end
      S_W_CTRL, S_W_DIV, S_W_SS, S_W_TX, S_W_GO, S_POLL, S_RD_RX: begin
        if (done_q) begin
          done_d  = 1'b0;
          state_d = after_access(state_q, busy_q);
        end else if (abort_s) begin
          done_d  = 1'b0;
          state_d = S_RESP;
        end else if (ack_s) begin
          done_d  = 1'b1;
        end else begin
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // Request capture, counters, poll status and response data.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      tx_q <= 32'h0; len_q <= 7'h0; mode_q <= 5'h0; div_q <= 16'h0; ss_q <= '0;
      tmo_q <= '0; poll_q <= '0; gap_q <= '0; busy_q <= 1'b0;
      rx_q <= 32'h0; err_q <= 1'b0;
    end else begin
      if (capture_s) begin
        tx_q   <= req_tx_data;
        len_q  <= req_char_len;
        mode_q <= req_mode;
        div_q  <= req_divider;
        ss_q   <= req_ss;
        poll_q <= '0;
        rx_q   <= 32'h0;
        err_q  <= 1'b0;
      end
      if (active_s && !wb_ack_i && !wb_err_i) tmo_q <= tmo_q + TMO_W'(1);
      else                                    tmo_q <= '0;
      if (state_q == S_GAP) gap_q <= gap_q + GAP_W'(1);
      else                  gap_q <= '0;
      if (ack_s && (state_q == S_POLL)) begin
        busy_q <= wb_dat_i[8];
        if (wb_dat_i[8]) poll_q <= poll_q + POLL_W'(1);
      end
      if (ack_s && (state_q == S_RD_RX)) rx_q <= wb_dat_i;
      if (abort_s) begin
        err_q <= 1'b1;
        rx_q  <= 32'h0;
      end
    end
  end

  // Output decode from the upcoming state so every port comes straight from a flop.
  always_comb begin
    cyc_d = is_bus(state_d) && !done_d;
    adr_d = 5'h0;
    dat_d = 32'h0;
    we_d  = 1'b0;
    if (cyc_d) begin
      case (state_d)
        S_W_CTRL: begin adr_d = ADR_CTRL; dat_d = ctrl_s;             we_d = 1'b1; end
        S_W_DIV:  begin adr_d = ADR_DIV;  dat_d = {16'h0, div_q};     we_d = 1'b1; end
        S_W_SS:   begin adr_d = ADR_SS;   dat_d = ss_word(ss_q);      we_d = 1'b1; end
        S_W_TX:   begin adr_d = ADR_TX0;  dat_d = tx_q;               we_d = 1'b1; end
        S_W_GO:   begin adr_d = ADR_CTRL; dat_d = ctrl_s | 32'h100;   we_d = 1'b1; end
        S_POLL:   begin adr_d = ADR_CTRL; dat_d = 32'h0;              we_d = 1'b0; end
        S_RD_RX:  begin adr_d = ADR_TX0;  dat_d = 32'h0;              we_d = 1'b0; end
        default:  begin adr_d = 5'h0;     dat_d = 32'h0;              we_d = 1'b0; end
      endcase
    end else begin
      adr_d = 5'h0;
      dat_d = 32'h0;
      we_d  = 1'b0;
    end
    sel_d       = cyc_d ? 4'hF : 4'h0;
    rsp_valid_d = (state_d == S_RESP);
    req_ready_d = (state_d == S_IDLE);
  end

  // Output registers.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      cyc_q <= 1'b0; adr_q <= 5'h0; dat_q <= 32'h0; we_q <= 1'b0; sel_q <= 4'h0;
      rsp_valid_q <= 1'b0; req_ready_q <= 1'b1;
    end else begin
      cyc_q <= cyc_d; adr_q <= adr_d; dat_q <= dat_d; we_q <= we_d; sel_q <= sel_d;
      rsp_valid_q <= rsp_valid_d; req_ready_q <= req_ready_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign rsp_valid   = rsp_valid_q;
  assign req_ready   = req_ready_q;
  assign rsp_rx_data = rx_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Bench for spi_wb_sequencer: a zero-wait Wishbone stub stands in for spi_top;
// expected bus accesses and responses are queued when a request is issued.
module tb_spi_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_tx_data, rsp_rx_data;
  logic [6:0]  req_char_len;
  logic [4:0]  req_mode;
  logic [15:0] req_divider;
  logic [7:0]  req_ss;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  spi_wb_sequencer #(.SS_NB(8), .ACK_TIMEOUT(64), .MAX_POLLS(3), .POLL_GAP(4)) dut (
    .wb_clk_in(clk), .wb_rst_in(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tx_data(req_tx_data),
    .req_char_len(req_char_len), .req_mode(req_mode), .req_divider(req_divider), .req_ss(req_ss),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rx_data(rsp_rx_data), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  int vec_cnt = 0;
  int mis_cnt = 0;
  logic [63:0] exp_bus[$];
  logic [63:0] exp_rsp[$];

  // Stub configuration
  logic        hang_en = 1'b0;
  logic [4:0]  hang_adr = 5'h0;
  logic        err_en = 1'b0;
  logic [4:0]  err_adr = 5'h0;
  logic        busy_forever = 1'b0;
  int          busy_polls = 0;
  int          polls_base = 0;
  int          polls_total = 0;
  logic [31:0] stub_rx = 32'h0;
  logic        stub_busy;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] enc(input logic we, input logic [4:0] adr, input logic [31:0] dat);
    return {26'h0, we, adr, dat};
  endfunction

  assign stub_busy = busy_forever || ((polls_total - polls_base) < busy_polls);

  // Zero-wait slave: ack in the strobe cycle unless told to hang; optional error.
  always_comb begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    if (wb_cyc_o && wb_stb_o) begin
      if (hang_en && wb_adr_o == hang_adr) begin
        wb_ack_i = 1'b0;
      end else begin
        wb_ack_i = 1'b1;
        wb_err_i = err_en && (wb_adr_o == err_adr);
      end
      if (!wb_we_o && wb_adr_o == 5'h10)      wb_dat_i = {23'h0, stub_busy, 8'h0};
      else if (!wb_we_o && wb_adr_o == 5'h00) wb_dat_i = stub_rx;
    end
  end

  // Count completed CTRL reads so the stub can report busy for N polls.
  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_we_o && wb_adr_o == 5'h10)
      polls_total <= polls_total + 1;
  end

  // Scoreboard: compare completed accesses and response handshakes.
  always @(negedge clk) begin
    logic [63:0] got, exp;
    if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
      got = enc(wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0);
      exp = (exp_bus.size() != 0) ? exp_bus.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      chk_eq("bus_access", got, exp);
      chk_eq("bus_sel", {60'h0, wb_sel_o}, 64'hF);
    end
    if (rsp_valid && rsp_ready) begin
      got = {31'h0, rsp_err, rsp_rx_data};
      exp = (exp_rsp.size() != 0) ? exp_rsp.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      chk_eq("rsp", got, exp);
    end
  end

  task automatic push_bus(input logic [4:0] mode, input logic [6:0] len, input logic [15:0] div,
                          input logic [7:0] ss, input logic [31:0] tx,
                          input int n_wr, input int n_poll, input bit rd_rx);
    logic [31:0] ctrl;
    logic [63:0] wr[5];
    ctrl  = {18'h0, mode[4:2], mode[1], mode[0], 1'b0, 1'b0, len};
    wr[0] = enc(1'b1, 5'h10, ctrl);
    wr[1] = enc(1'b1, 5'h14, {16'h0, div});
    wr[2] = enc(1'b1, 5'h18, {24'h0, ss});
    wr[3] = enc(1'b1, 5'h00, tx);
    wr[4] = enc(1'b1, 5'h10, ctrl | 32'h100);
    for (int i = 0; i < n_wr; i++) exp_bus.push_back(wr[i]);
    for (int i = 0; i < n_poll; i++) exp_bus.push_back(enc(1'b0, 5'h10, 32'h0));
    if (rd_rx) exp_bus.push_back(enc(1'b0, 5'h00, 32'h0));
  endtask

  task automatic drive_req(input string tag, input logic [4:0] mode, input logic [6:0] len,
                           input logic [15:0] div, input logic [7:0] ss, input logic [31:0] tx);
    req_mode = mode; req_char_len = len; req_divider = div; req_ss = ss; req_tx_data = tx;
    chk_eq({tag, "_req_ready"}, {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [4:0] mode, input logic [6:0] len,
                     input logic [15:0] div, input logic [7:0] ss, input logic [31:0] tx,
                     input int busy_n, input int n_wr, input int n_poll, input bit rd_rx,
                     input int exp_lat, input bit exp_err, input logic [31:0] exp_dat,
                     input int hold, input bit early);
    int cnt;
    polls_base = polls_total;
    busy_polls = busy_n;
    push_bus(mode, len, div, ss, tx, n_wr, n_poll, rd_rx);
    exp_rsp.push_back({31'h0, exp_err, exp_dat});
    rsp_ready = early;
    drive_req(tag, mode, len, div, ss, tx);
    cnt = 0;
    while (!rsp_valid && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk_eq({tag, "_latency"}, cnt, exp_lat);
    chk_eq({tag, "_cyc_idle"}, {63'h0, wb_cyc_o}, 64'h0);
    for (int i = 0; i < hold; i++) begin
      chk_eq({tag, "_hold_valid"}, {63'h0, rsp_valid}, 64'h1);
      chk_eq({tag, "_hold_data"}, {32'h0, rsp_rx_data}, {32'h0, exp_dat});
      chk_eq({tag, "_hold_busy"}, {63'h0, req_ready}, 64'h0);
      req_valid = (i == 3);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk_eq({tag, "_post_valid"}, {63'h0, rsp_valid}, 64'h0);
    chk_eq({tag, "_post_ready"}, {63'h0, req_ready}, 64'h1);
  endtask

  initial begin
    bit found;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_tx_data = 32'h0; req_char_len = 7'h0; req_mode = 5'h0; req_divider = 16'h0; req_ss = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_cyc", {63'h0, wb_cyc_o}, 64'h0);
    chk_eq("rst_stb", {63'h0, wb_stb_o}, 64'h0);
    chk_eq("rst_bus", {wb_sel_o, wb_we_o, wb_adr_o, wb_dat_o}, 64'h0);
    chk_eq("rst_rsp", {rsp_valid, rsp_err, rsp_rx_data}, 64'h0);
    chk_eq("rst_req_ready", {63'h0, req_ready}, 64'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: one busy poll then done
    stub_rx = 32'h0000_000B;
    run("t1", 5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f, 1, 5, 2, 1'b1, 24, 1'b0, 32'hB, 0, 1'b0);
    // T2: lsb/tx_neg variants; rsp_ready held high in advance
    stub_rx = 32'h0000_0005;
    run("t2a", 5'b11110, 7'd4, 16'd4, 8'h01, 32'h236f, 0, 5, 1, 1'b1, 18, 1'b0, 32'h5, 0, 1'b1);
    stub_rx = 32'h1234_5678;
    run("t2b", 5'b11010, 7'd0, 16'hABCD, 8'h80, 32'hDEAD_BEEF, 2, 5, 3, 1'b1, 30, 1'b0, 32'h1234_5678, 0, 1'b0);
    // T3: DIVIDER write never acked
    hang_en = 1'b1; hang_adr = 5'h14;
    run("t3", 5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f, 0, 1, 0, 1'b0, 66, 1'b1, 32'h0, 0, 1'b0);
    hang_en = 1'b0;
    // T4: GO_BSY stuck, poll limit of 3
    busy_forever = 1'b1;
    run("t4", 5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f, 0, 5, 3, 1'b0, 27, 1'b1, 32'h0, 0, 1'b0);
    busy_forever = 1'b0;
    // Bus error on SS write with ack also high: error wins
    err_en = 1'b1; err_adr = 5'h18;
    run("t7", 5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f, 0, 2, 0, 1'b0, 5, 1'b1, 32'h0, 0, 1'b0);
    err_en = 1'b0;

    // T5: reset during POLL, no response expected
    polls_base = polls_total;
    busy_polls = 2;
    push_bus(5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f, 5, 1, 1'b0);
    drive_req("t5", 5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (wb_cyc_o && !wb_we_o && wb_adr_o == 5'h10) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk_eq("t5_poll_seen", {63'h0, found}, 64'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("t5_cyc", {63'h0, wb_cyc_o}, 64'h0);
    chk_eq("t5_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk_eq("t5_req_ready", {63'h0, req_ready}, 64'h1);
    stub_rx = 32'h0000_0009;
    run("t5b", 5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f, 0, 5, 1, 1'b1, 18, 1'b0, 32'h9, 0, 1'b0);

    // T6: response held 10 cycles, request pulse ignored meanwhile
    stub_rx = 32'h0000_000C;
    run("t6", 5'b11101, 7'd4, 16'd4, 8'h01, 32'h236f, 0, 5, 1, 1'b1, 18, 1'b0, 32'hC, 10, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk_eq("bus_queue_left", exp_bus.size(), 64'h0);
    chk_eq("rsp_queue_left", exp_rsp.size(), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
